// File: rtl/sim_pkg.sv
// Shared definitions for the Verlet rope simulation: scheduler FSM states,
// default rope geometry and index-width helpers used by the node array too.
package sim_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    VERLET    = 2'd1,
    CONSTRAIN = 2'd2,
    DONE      = 2'd3
  } sched_state_t;

  localparam int DEF_NUM_NODES        = 8;
  localparam int DEF_CONSTRAINT_ITERS = 4;

  // Index width for a counter spanning 0..n-1, never narrower than 1 bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int PAIR_W_DEF = idx_w(DEF_NUM_NODES - 1);
  localparam int ITER_W_DEF = idx_w(DEF_CONSTRAINT_ITERS);

endpackage

// File: rtl/sched_pair_iter_counter.sv
// Nested constraint-pair / pass counter for the frame scheduler.
// Ports: clk, reset, clr, en in; pair_idx, iter_idx, last_pair_last_iter out.
module sched_pair_iter_counter #(
  parameter int NUM_PAIRS = 7,
  parameter int NUM_ITERS = 4,
  parameter int PAIR_W    = 3,
  parameter int ITER_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr,
  input  logic              en,
  output logic [PAIR_W-1:0] pair_idx,
  output logic [ITER_W-1:0] iter_idx,
  output logic              last_pair_last_iter
);

  logic last_pair;
  logic last_iter;

  assign last_pair = (pair_idx == PAIR_W'(NUM_PAIRS - 1));
  assign last_iter = (iter_idx == ITER_W'(NUM_ITERS - 1));
  assign last_pair_last_iter = last_pair & last_iter;

  // Wrapping the final pair of the final pass lands both at 0, so the
  // counter is already cleared when the FSM reaches DONE.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      pair_idx <= '0;
      iter_idx <= '0;
    end else if (en) begin
      if (last_pair) begin
        pair_idx <= '0;
        iter_idx <= last_iter ? '0 : iter_idx + ITER_W'(1);
      end else begin
        pair_idx <= pair_idx + PAIR_W'(1);
      end
    end
  end

endmodule

// File: rtl/sim_step_scheduler.sv
// Frame sequencer for the rope node array: one Verlet strobe, then
// CONSTRAINT_ITERS passes over all adjacent pairs, then a done pulse.
// Ports: clk, reset, frame_tick, run, render_busy in;
//   verlet_state, fix_constraint_state, pair_idx, iter_idx, busy,
//   frame_done, frame_count, overrun_count out.
module sim_step_scheduler
  import sim_pkg::*;
#(
  parameter int NUM_NODES        = DEF_NUM_NODES,
  parameter int CONSTRAINT_ITERS = DEF_CONSTRAINT_ITERS,
  parameter int FRAME_CNT_W      = 16,
  localparam int PAIR_W          = idx_w(NUM_NODES - 1),
  localparam int ITER_W          = idx_w(CONSTRAINT_ITERS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  input  logic                   run,
  input  logic                   render_busy,
  output logic                   verlet_state,
  output logic                   fix_constraint_state,
  output logic [PAIR_W-1:0]      pair_idx,
  output logic [ITER_W-1:0]      iter_idx,
  output logic                   busy,
  output logic                   frame_done,
  output logic [FRAME_CNT_W-1:0] frame_count,
  output logic [7:0]             overrun_count
);

  sched_state_t state_q;
  sched_state_t state_d;
  logic         pending_q;
  logic         accept;
  logic         in_constrain;
  logic         last_step;

  assign accept = (state_q == IDLE) & (frame_tick | pending_q)
                & run & ~render_busy;
  assign in_constrain = (state_q == CONSTRAIN);
  assign busy = (state_q != IDLE);

  sched_pair_iter_counter #(
    .NUM_PAIRS (NUM_NODES - 1),
    .NUM_ITERS (CONSTRAINT_ITERS),
    .PAIR_W    (PAIR_W),
    .ITER_W    (ITER_W)
  ) u_cnt (
    .clk                 (clk),
    .reset               (reset),
    .clr                 (~in_constrain),
    .en                  (in_constrain),
    .pair_idx            (pair_idx),
    .iter_idx            (iter_idx),
    .last_pair_last_iter (last_step)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    verlet_state         = 1'b0;
    fix_constraint_state = 1'b0;
    frame_done           = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = VERLET;
      end
      VERLET: begin
        verlet_state = 1'b1;
        state_d      = CONSTRAIN;
      end
      CONSTRAIN: begin
        fix_constraint_state = 1'b1;
        if (last_step) state_d = DONE;
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // One-deep request latch. A tick that finds a request already latched
  // is a dropped frame, even if that latched request starts right now.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q     <= 1'b0;
      overrun_count <= '0;
      frame_count   <= '0;
    end else begin
      if (accept) begin
        pending_q <= 1'b0;
      end else if (frame_tick) begin
        pending_q <= 1'b1;
      end
      if (frame_tick && pending_q && overrun_count != 8'hFF) begin
        overrun_count <= overrun_count + 8'd1;
      end
      if (state_q == DONE) begin
        frame_count <= frame_count + FRAME_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_sim_step_scheduler.sv
// Self-checking bench for sim_step_scheduler (8 nodes, 4 passes).
// Strobe trace is scoreboarded per cycle; counters checked at frame ends.
module tb_sim_step_scheduler;

  localparam int NN = 8;
  localparam int IT = 4;
  localparam int P  = NN - 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_tick;
  logic        run;
  logic        render_busy;
  logic        verlet_state;
  logic        fix_constraint_state;
  logic [2:0]  pair_idx;
  logic [1:0]  iter_idx;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;
  logic [7:0]  overrun_count;

  always #5 clk = ~clk;

  sim_step_scheduler #(
    .NUM_NODES        (NN),
    .CONSTRAINT_ITERS (IT),
    .FRAME_CNT_W      (16)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .frame_tick           (frame_tick),
    .run                  (run),
    .render_busy          (render_busy),
    .verlet_state         (verlet_state),
    .fix_constraint_state (fix_constraint_state),
    .pair_idx             (pair_idx),
    .iter_idx             (iter_idx),
    .busy                 (busy),
    .frame_done           (frame_done),
    .frame_count          (frame_count),
    .overrun_count        (overrun_count)
  );

  typedef struct packed {
    logic       v;
    logic       f;
    logic [2:0] p;
    logic [1:0] i;
    logic       d;
  } strobe_t;

  typedef struct {
    logic tick;
    logic run;
    logic rb;
    logic start;
    int   ovr_inc;
  } vec_t;

  strobe_t exp_q[$];
  strobe_t ce;
  strobe_t ca;
  int      n_checks = 0;
  int      n_fail = 0;
  int      done_cnt = 0;
  int      exp_frames = 0;
  int      exp_ovr = 0;
  bit      chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      ce = '0;
      if (exp_q.size() > 0) ce = exp_q.pop_front();
      ca = {verlet_state, fix_constraint_state, pair_idx, iter_idx,
            frame_done};
      n_checks++;
      if (ca !== ce) begin
        n_fail++;
        $display("FAIL strobe @%0t: got v%b f%b p%0d i%0d d%b expected v%b f%b p%0d i%0d d%b",
                 $time, ca.v, ca.f, ca.p, ca.i, ca.d,
                 ce.v, ce.f, ce.p, ce.i, ce.d);
      end
      if (frame_done === 1'b1) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected trace from the cycle the accepting request is presented.
  task automatic push_frame();
    strobe_t r;
    r = '0;
    exp_q.push_back(r);
    r.v = 1'b1;
    exp_q.push_back(r);
    for (int it = 0; it < IT; it++) begin
      for (int pr = 0; pr < P; pr++) begin
        r = '0;
        r.f = 1'b1;
        r.p = pr[2:0];
        r.i = it[1:0];
        exp_q.push_back(r);
      end
    end
    r = '0;
    r.d = 1'b1;
    exp_q.push_back(r);
    exp_frames++;
  endtask

  task automatic wait_empty(input string name);
    int k;
    k = 0;
    while (exp_q.size() > 0 && k < 400) begin
      step();
      k++;
    end
    check({name, " drained"}, exp_q.size(), 0);
    check({name, " frame_count"}, int'(frame_count), exp_frames);
    check({name, " overrun_count"}, int'(overrun_count), exp_ovr);
  endtask

  task automatic tick_frame();
    frame_tick = 1'b1;
    push_frame();
    step();
    frame_tick = 1'b0;
  endtask

  vec_t vecs[9];
  int   d0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    frame_tick = 1'b0;
    run = 1'b1;
    render_busy = 1'b0;
    step();
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    check("reset busy", int'(busy), 0);
    check("reset frame_count", int'(frame_count), 0);
    check("reset overrun", int'(overrun_count), 0);

    // Reset in cycle 20 of a frame aborts it without a done pulse.
    tick_frame();
    repeat (19) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    exp_frames = 0;
    check("abort busy", int'(busy), 0);
    check("abort frame_count", int'(frame_count), 0);
    check("abort done pulses", done_cnt, 0);
    check("abort overrun", int'(overrun_count), 0);

    // Single frame.
    repeat (9) step();
    tick_frame();
    wait_empty("single");
    check("single done pulses", done_cnt, 1);

    // Renderer holds off the start; request latched.
    render_busy = 1'b1;
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (4) step();
    check("rb held busy", int'(busy), 0);
    render_busy = 1'b0;
    push_frame();
    wait_empty("rb release");

    // Three ticks during a busy frame: one queued, two dropped.
    d0 = done_cnt;
    tick_frame();
    repeat (3) step();
    for (int k = 0; k < 3; k++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      repeat (3) step();
    end
    exp_ovr += 2;
    push_frame();
    wait_empty("three ticks");
    check("three ticks done pulses", done_cnt - d0, 2);

    // Gating table from IDLE with no request latched.
    vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b0, 1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 1'b0, 0};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b1, 0};
    vecs[6] = '{1'b1, 1'b1, 1'b0, 1'b1, 0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1};
    for (int n = 0; n < 9; n++) begin
      frame_tick  = vecs[n].tick;
      run         = vecs[n].run;
      render_busy = vecs[n].rb;
      if (vecs[n].start) push_frame();
      exp_ovr += vecs[n].ovr_inc;
      step();
      frame_tick = 1'b0;
      check($sformatf("vec%0d busy", n), int'(busy), int'(vecs[n].start));
      check($sformatf("vec%0d overrun", n), int'(overrun_count), exp_ovr);
      if (vecs[n].start) wait_empty($sformatf("vec%0d", n));
    end
    run = 1'b1;
    render_busy = 1'b0;

    // Tick landing in the DONE cycle chains the next frame.
    tick_frame();
    repeat (29) step();
    check("done cycle reached", int'(frame_done), 1);
    tick_frame();
    wait_empty("done tick");

    // run dropped mid-frame: frame finishes, later tick is held.
    tick_frame();
    repeat (5) step();
    run = 1'b0;
    wait_empty("run0 frame");
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (5) step();
    check("run0 held busy", int'(busy), 0);
    run = 1'b1;
    push_frame();
    wait_empty("run resume");

    // 300 ticks under render_busy saturate the drop counter.
    render_busy = 1'b1;
    for (int k = 0; k < 300; k++) begin
      frame_tick = 1'b1;
      step();
    end
    frame_tick = 1'b0;
    exp_ovr = (exp_ovr + 299 > 255) ? 255 : exp_ovr + 299;
    check("sat overrun", int'(overrun_count), exp_ovr);
    check("sat busy", int'(busy), 0);
    render_busy = 1'b0;
    push_frame();
    wait_empty("sat release");
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
